inst_mem_ctrl: RTL and testbench
================================

Name: inst_mem_ctrl

Overview:
Parametrised instruction memory for the processor front end. It replaces a hard-coded ROM that was loaded on the first clock with a synchronous RAM. Features: a post-reset clear sequence, a host load port for writing programs, a valid/ready fetch handshake with a registered response and backpressure, and out-of-range detection. It sits between the PC/fetch stage and the decode stage.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 16, fetch/load address width in bits
DEPTH, 16, number of instruction words; DEPTH <= 2**ADDR_W

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  fetch request valid
req_addr  input  ADDR_W  fetch word address
req_ready  output  1  fetch request accepted when req_valid & req_ready
resp_valid  output  1  response register holds valid data
resp_data  output  DATA_W  fetched instruction
resp_err  output  1  fetched address was >= DEPTH
resp_ready  input  1  consumer takes the response when resp_valid & resp_ready
load_valid  input  1  host write request
load_addr  input  ADDR_W  host write word address
load_data  input  DATA_W  host write data
load_ready  output  1  host write accepted when load_valid & load_ready
busy  output  1  clear sequence in progress

Behaviour:
- Reset (rst_n=0 at a clk edge): state<=CLEAR, clr_ptr<=0, resp_valid<=0, resp_data<=0, resp_err<=0. This also applies mid-fetch or mid-clear: any pending response is dropped.
- State CLEAR:
  - Each cycle writes 0 (NOP) to mem[clr_ptr], then clr_ptr++.
  - After writing DEPTH-1, go to RUN. CLEAR lasts exactly DEPTH cycles.
  - busy=1, req_ready=0, load_ready=0 throughout.
- State RUN: busy=0, load_ready=1, req_ready = !resp_valid | resp_ready. The response stage is a one-entry buffer and is never overwritten while stalled.
- Fetch, 1-cycle latency:
  - On an accepted request at edge N, resp_valid=1 after edge N.
  - addr < DEPTH: resp_data=mem[addr], resp_err=0.
  - addr >= DEPTH: resp_data=0, resp_err=1. No wrap-around or aliasing.
- Response handshake:
  - resp_valid clears after an edge with resp_ready=1 and no new accepted request.
  - Accept and consume in the same cycle gives back-to-back responses at full throughput.
  - resp_data and resp_err stay stable while resp_valid=1 and resp_ready=0.
- Load:
  - Accepted load with addr < DEPTH writes mem[addr] at that edge.
  - addr >= DEPTH: silently discarded, memory unchanged.
- Same-cycle load and fetch to the same in-range address: write-first, so the response carries load_data.
- Memory contents are not reset-cleared directly; only the CLEAR sequence zeroes them. Loads made before a reset are lost.
- Width rules:
  - clr_ptr is $clog2(DEPTH) bits.
  - Range compare uses the full ADDR_W-bit address; the memory index is the low bits only after the range check passes.

Optional Feature:
INSTMEM_STATS_EN
- Defined:
  - Adds output fetch_count [31:0] and output err_count [15:0], both reset to 0 and cleared when leaving CLEAR.
  - fetch_count increments on every accepted fetch; err_count increments on every accepted out-of-range fetch.
  - Both saturate at all-ones and never wrap.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then idle (DEPTH=16) -> busy=1 for exactly 16 cycles, req_ready=0 and load_ready=0 meanwhile. Fetching addresses 0..15 afterwards returns 0 with resp_err=0.
- Load mem[1]=32'h58010000 and mem[2]=32'h04201000, then fetch 1, 2 with resp_ready=1 -> responses on consecutive cycles with matching data and no bubbles.
- Fetch addr 16 and addr 16'hFFFF -> resp_err=1, resp_data=0. Load to addr 20 followed by fetch of addr 4 -> mem[4] unchanged (0).
- Hold resp_ready=0 for 5 cycles after fetching addr 3 -> resp_data stable, req_ready=0. A new request is accepted on the cycle resp_ready rises.
- Same-cycle load addr 5=32'hDEADBEEF and fetch addr 5 -> response 32'hDEADBEEF. Assert rst_n=0 mid-stall -> resp_valid=0 next cycle and CLEAR restarts, with mem[5] reading 0 afterwards.
- With INSTMEM_STATS_EN: 10 fetches including 3 out-of-range -> fetch_count=10, err_count=3. Force fetch_count to 32'hFFFFFFFF and fetch again -> it stays at 32'hFFFFFFFF.

Source files
------------

// File: rtl/inst_mem_ctrl_if.sv
// Fetch, response and host-load signals between the front end and the instruction memory.
// The master side issues fetches and loads; the slave side is the memory controller.
interface inst_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              resp_ready;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              busy;

    modport master (
        output req_valid, req_addr, resp_ready, load_valid, load_addr, load_data,
        input  req_ready, resp_valid, resp_data, resp_err, load_ready, busy
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, load_valid, load_addr, load_data,
        output req_ready, resp_valid, resp_data, resp_err, load_ready, busy
    );
endinterface

// File: rtl/inst_mem_ctrl.sv
// Synchronous instruction RAM: post-reset clear, host load port, registered fetch with backpressure.
// Optional fetch/error statistics counters are built when INSTMEM_STATS_EN is defined.
module inst_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    inst_mem_ctrl_if.slave mem_bus
`ifdef INSTMEM_STATS_EN
    ,
    output logic [31:0]    fetch_count,
    output logic [15:0]    err_count
`endif
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PTR_W-1:0]  clr_ptr;
    logic              clr_done;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req_fire_p0;
    logic              load_fire_p0;
    logic              req_hit_p0;
    logic              load_hit_p0;
    logic [PTR_W-1:0]  req_idx_p0;
    logic [PTR_W-1:0]  load_idx_p0;
    logic [DATA_W-1:0] rd_data_p0;

`ifdef INSTMEM_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= (state == CLEAR && !clr_done) ? clr_ptr + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt          = state;
        clr_done           = 1'b0;
        mem_bus.busy       = 1'b0;
        mem_bus.load_ready = 1'b0;
        mem_bus.req_ready  = 1'b0;
        case (state)
            CLEAR: begin
                mem_bus.busy = 1'b1;
                clr_done     = (clr_ptr == LAST_PTR);
                if (clr_done) state_nxt = RUN;
            end
            RUN: begin
                mem_bus.load_ready = 1'b1;
                // One-entry response buffer: accept only if it is empty or being drained.
                mem_bus.req_ready  = !mem_bus.resp_valid || mem_bus.resp_ready;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Stage p0: handshake decode, full-width range check, write-first read mux.
    always_comb begin
        req_fire_p0  = mem_bus.req_valid && mem_bus.req_ready;
        load_fire_p0 = mem_bus.load_valid && mem_bus.load_ready;
        req_hit_p0   = {1'b0, mem_bus.req_addr} < DEPTH_X;
        load_hit_p0  = {1'b0, mem_bus.load_addr} < DEPTH_X;
        req_idx_p0   = mem_bus.req_addr[PTR_W-1:0];
        load_idx_p0  = mem_bus.load_addr[PTR_W-1:0];
        if (load_fire_p0 && load_hit_p0 && load_idx_p0 == req_idx_p0)
            rd_data_p0 = mem_bus.load_data;
        else
            rd_data_p0 = mem[req_idx_p0];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR)
                mem[clr_ptr] <= '0;
            else if (load_fire_p0 && load_hit_p0)
                mem[load_idx_p0] <= mem_bus.load_data;
        end
    end

    // Stage p1: registered response, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_bus.resp_valid <= 1'b0;
            mem_bus.resp_data  <= '0;
            mem_bus.resp_err   <= 1'b0;
        end else if (req_fire_p0) begin
            mem_bus.resp_valid <= 1'b1;
            mem_bus.resp_data  <= req_hit_p0 ? rd_data_p0 : '0;
            mem_bus.resp_err   <= !req_hit_p0;
        end else if (mem_bus.resp_ready) begin
            mem_bus.resp_valid <= 1'b0;
        end
    end

`ifdef INSTMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || clr_done) begin
            fetch_count <= '0;
            err_count   <= '0;
        end else if (req_fire_p0) begin
            fetch_count <= sat_inc32(fetch_count);
            if (!req_hit_p0) err_count <= sat_inc16(err_count);
        end
    end
`endif

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Bench for inst_mem_ctrl: vector table plus hand-written stall/reset sequences, scoreboard on responses.
module tb_inst_mem_ctrl;

    logic clk;
    logic rst_n;

    inst_mem_ctrl_if #(.DATA_W(32), .ADDR_W(16)) bus ();

`ifdef INSTMEM_STATS_EN
    logic [31:0] fetch_count;
    logic [15:0] err_count;
`endif

    inst_mem_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_bus (bus)
`ifdef INSTMEM_STATS_EN
        ,
        .fetch_count (fetch_count),
        .err_count   (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    typedef struct {
        logic        ld_v;
        logic [15:0] ld_a;
        logic [31:0] ld_d;
        logic        rq_v;
        logic [15:0] rq_a;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] cur_d;
    logic        cur_e;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Response monitor: pop on consumption, push the expected result when a fetch is accepted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_valid && bus.resp_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL resp_unexpected: got data=%h err=%b, required no response",
                             bus.resp_data, bus.resp_err);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.resp_data !== e.d || bus.resp_err !== e.e) begin
                        n_err++;
                        $display("FAIL resp: got data=%h err=%b, required data=%h err=%b",
                                 bus.resp_data, bus.resp_err, e.d, e.e);
                    end
                end
            end
            if (bus.req_valid && bus.req_ready) sb.push_back('{d: cur_d, e: cur_e});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.load_valid  = 1'b0;
        bus.resp_ready  = 1'b1;
        step();
        @(negedge clk);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd1);
        step();
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_clear();
        int cnt;
        logic rdy_seen;
        cnt = 0;
        rdy_seen = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cnt++;
            if (bus.req_ready || bus.load_ready) rdy_seen = 1'b1;
        end
        check("clear_cycles", cnt, 32'd16);
        check("clear_ready_low", {31'd0, rdy_seen}, 32'd0);
        step();
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        check("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic fetch(input logic [15:0] a, input logic [31:0] d, input logic e);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        cur_d         = d;
        cur_e         = e;
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 16'd1,     32'h58010000, 1'b0, 16'd0,     32'h0,        1'b0};
        vecs[1]  = '{1'b1, 16'd2,     32'h04201000, 1'b0, 16'd0,     32'h0,        1'b0};
        vecs[2]  = '{1'b0, 16'd0,     32'h0,        1'b1, 16'd1,     32'h58010000, 1'b0};
        vecs[3]  = '{1'b0, 16'd0,     32'h0,        1'b1, 16'd2,     32'h04201000, 1'b0};
        vecs[4]  = '{1'b0, 16'd0,     32'h0,        1'b1, 16'd16,    32'h0,        1'b1};
        vecs[5]  = '{1'b0, 16'd0,     32'h0,        1'b1, 16'hFFFF,  32'h0,        1'b1};
        vecs[6]  = '{1'b1, 16'd20,    32'h12345678, 1'b0, 16'd0,     32'h0,        1'b0};
        vecs[7]  = '{1'b0, 16'd0,     32'h0,        1'b1, 16'd4,     32'h0,        1'b0};
        vecs[8]  = '{1'b1, 16'd5,     32'hDEADBEEF, 1'b1, 16'd5,     32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b0, 16'd0,     32'h0,        1'b1, 16'd0,     32'h0,        1'b0};
        vecs[10] = '{1'b1, 16'd15,    32'hA5A5A5A5, 1'b0, 16'd0,     32'h0,        1'b0};
        vecs[11] = '{1'b0, 16'd0,     32'h0,        1'b1, 16'd15,    32'hA5A5A5A5, 1'b0};
        vecs[12] = '{1'b0, 16'd0,     32'h0,        1'b1, 16'h8001,  32'h0,        1'b1};

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        cur_d          = '0;
        cur_e          = 1'b0;

        do_reset();
        wait_clear();

        // Every word reads back as zero after the clear sequence.
        for (int a = 0; a < 16; a++) fetch(16'(a), 32'h0, 1'b0);
        drain();

        for (int i = 0; i < 13; i++) begin
            bus.load_valid = vecs[i].ld_v;
            bus.load_addr  = vecs[i].ld_a;
            bus.load_data  = vecs[i].ld_d;
            bus.req_valid  = vecs[i].rq_v;
            bus.req_addr   = vecs[i].rq_a;
            cur_d          = vecs[i].exp_d;
            cur_e          = vecs[i].exp_e;
            @(negedge clk);
            if (vecs[i].rq_v) check("vec_req_ready", {31'd0, bus.req_ready}, 32'd1);
            if (vecs[i].ld_v) check("vec_load_ready", {31'd0, bus.load_ready}, 32'd1);
            check("vec_resp_valid", {31'd0, bus.resp_valid},
                  (i > 0 && vecs[i-1].rq_v) ? 32'd1 : 32'd0);
            step();
        end
        bus.load_valid = 1'b0;
        bus.req_valid  = 1'b0;
        drain();

        // Stall: response for addr 3 held for 5 cycles while a new request waits.
        bus.load_valid = 1'b1;
        bus.load_addr  = 16'd3;
        bus.load_data  = 32'h33333333;
        step();
        bus.load_valid = 1'b0;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 16'd3;
        cur_d          = 32'h33333333;
        cur_e          = 1'b0;
        step();
        bus.req_addr = 16'd4;
        cur_d        = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("stall_data", bus.resp_data, 32'h33333333);
            check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
            step();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", {31'd0, bus.req_ready}, 32'd1);
        step();
        bus.req_valid = 1'b0;
        drain();

        // Reset while a response is stalled drops it and restarts the clear.
        bus.resp_ready = 1'b0;
        fetch(16'd5, 32'hDEADBEEF, 1'b0);
        step();
        step();
        do_reset();
        wait_clear();
        fetch(16'd5, 32'h0, 1'b0);
        drain();

`ifdef INSTMEM_STATS_EN
        do_reset();
        wait_clear();
        check("stats_reset_fetch", fetch_count, 32'd0);
        fetch(16'd0, 32'h0, 1'b0);
        fetch(16'd1, 32'h0, 1'b0);
        fetch(16'd16, 32'h0, 1'b1);
        fetch(16'd2, 32'h0, 1'b0);
        fetch(16'd3, 32'h0, 1'b0);
        fetch(16'd100, 32'h0, 1'b1);
        fetch(16'd4, 32'h0, 1'b0);
        fetch(16'd5, 32'h0, 1'b0);
        fetch(16'hFFFF, 32'h0, 1'b1);
        fetch(16'd6, 32'h0, 1'b0);
        drain();
        check("stats_fetch_count", fetch_count, 32'd10);
        check("stats_err_count", {16'd0, err_count}, 32'd3);
        force dut.fetch_count = 32'hFFFFFFFF;
        #1;
        release dut.fetch_count;
        fetch(16'd7, 32'h0, 1'b0);
        drain();
        check("stats_fetch_sat", fetch_count, 32'hFFFFFFFF);
        check("stats_err_hold", {16'd0, err_count}, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
